io_controller: RTL and testbench

- Memory-mapped console/power controller between the core's store path and the byte-output sink.
- Buffers TXDATA writes in a FIFO and drains them over a valid/ready byte stream.
- A POWER write first drains all buffered bytes, then raises power_off.
- Exposes a STATUS word for polling by software.

---
 rtl/io_pkg.sv | 13 +
 rtl/io_fifo.sv | 44 ++++
 rtl/io_controller.sv | 76 +++++++
 tb/tb_io_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared address map, controller states and STATUS bit positions
package io_pkg;
  localparam logic [1:0] IO_OUT    = 2'd0;
  localparam logic [1:0] IO_POWER  = 2'd1;
  localparam logic [1:0] IO_STATUS = 2'd2;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_DRAIN = 3;
  localparam int ST_OFF   = 4;
  localparam int ST_CNT   = 8;
  typedef enum logic [1:0] {RUN, DRAIN, OFF} state_e;
endpackage

// File: rtl/io_fifo.sv
// io_fifo: power-of-two synchronous FIFO with occupancy count and registered storage
module io_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  // occupancy follows push/pop; simultaneous push and pop leave it unchanged
  always_comb cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: contents are only visible while non-empty
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/io_controller.sv
// io_controller: console byte FIFO, power shutdown sequencing and STATUS register
module io_controller
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memory_in,
  input  logic [3:2]  address,
  input  logic [3:0]  write_enable,
  input  logic        read_enable,
  output logic [31:0] memory_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        power_off
);
  state_e state_q, state_d;
  logic ovf_q, ovf_d;
  logic [31:0] mo_q, mo_d, status;
  logic wr, tx_wr, push, ovf_set, ovf_clr, pop, full, empty;
  logic [CNT_W-1:0] count;
  logic unused_bits;
  assign unused_bits = ^memory_in[31:8];
  assign wr         = write_enable == 4'hF;
  assign tx_wr      = wr && address == IO_OUT && state_q == RUN;
  assign push       = tx_wr && !full;
  assign ovf_set    = tx_wr && full;
  assign ovf_clr    = wr && address == IO_STATUS && memory_in[ST_OVF] && state_q != OFF;
  assign pop        = tx_valid && tx_ready;
  assign tx_valid   = !empty;
  assign power_off  = state_q == OFF;
  assign memory_out = mo_q;
  io_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (memory_in[7:0]),
    .data_o  (tx_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  // software-visible status word
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVF] = ovf_q;
    status[ST_DRAIN] = state_q == DRAIN;
    status[ST_OFF] = state_q == OFF;
    status[ST_CNT +: 8] = 8'(count);
  end
  // shutdown sequencing, sticky overflow (set beats clear) and registered read data
  always_comb begin
    state_d = (state_q == RUN && wr && address == IO_POWER) ? DRAIN :
              (state_q == DRAIN && empty) ? OFF : state_q;
    ovf_d = ovf_set ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    mo_d = read_enable ? ((address == IO_STATUS) ? status : 32'h0) : mo_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ovf_q   <= 1'b0;
      mo_q    <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      mo_q    <= mo_d;
    end
  end
endmodule

// File: tb/tb_io_controller.sv
// tb_io_controller: randomized and directed checks of io_controller against a queue-based model
module tb_io_controller;
  localparam int DEPTH = 16;
  logic clk = 0, reset = 1, read_enable = 0, tx_ready = 0;
  logic [31:0] memory_in = 0;
  logic [1:0] address = 0;
  logic [3:0] write_enable = 0;
  logic [31:0] memory_out;
  logic [7:0] tx_data;
  logic tx_valid, power_off;
  int n_tests = 0, n_fail = 0;
  byte unsigned q[$], exp_out[$], seen[$];
  bit m_ovf, m_drain, m_off;
  logic [31:0] m_mo;

  always #5 clk = ~clk;

  io_controller #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .memory_in    (memory_in),
    .address      (address),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .memory_out   (memory_out),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .power_off    (power_off)
  );

  function automatic logic [31:0] m_status();
    int n = q.size();
    return 32'((n == 0) + 2 * (n == DEPTH) + 4 * m_ovf + 8 * m_drain + 16 * m_off + 256 * n);
  endfunction

  task automatic cycle();
    bit wr, full, set, clr, go_drain, go_off;
    logic [31:0] st;
    wr = write_enable == 4'hF;
    if (reset) begin
      q.delete();
      m_ovf = 0;
      m_drain = 0;
      m_off = 0;
      m_mo = 0;
    end else begin
      if (tx_valid && tx_ready) seen.push_back(tx_data);
      st = m_status();
      full = q.size() == DEPTH;
      go_drain = wr && address == 2'd1 && !m_drain && !m_off;
      go_off = m_drain && q.size() == 0;
      set = wr && address == 2'd0 && !m_drain && !m_off && full;
      clr = wr && address == 2'd2 && memory_in[2] && !m_off;
      if (read_enable) m_mo = (address == 2'd2) ? st : 32'h0;
      if (tx_ready && q.size() > 0) exp_out.push_back(q.pop_front());
      if (wr && address == 2'd0 && !m_drain && !m_off && !full) q.push_back(memory_in[7:0]);
      m_ovf = set | (m_ovf & !clr);
      m_drain = (m_drain & !go_off) | go_drain;
      m_off = m_off | go_off;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] a, input logic [31:0] d, input logic [3:0] we, input bit re);
    address = a;
    memory_in = d;
    write_enable = we;
    read_enable = re;
    cycle();
    write_enable = 0;
    read_enable = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    reset = 1;
    idle(2);
    reset = 0;
    seen.delete();
    exp_out.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_tests++; if (power_off !== 1'b0) begin n_fail++; $display("FAIL reset_power_off: got %b want 0", power_off); end
    n_tests++; if (memory_out !== 32'h0) begin n_fail++; $display("FAIL reset_memory_out: got %h want 0", memory_out); end
    drive(2'd2, 32'h0, 4'h0, 1);
    n_tests++; if (memory_out !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h want 00000001", memory_out); end
  endtask

  task automatic test_basic();
    logic [7:0] want[3];
    want = '{8'h41, 8'h42, 8'h43};
    do_reset();
    tx_ready = 1;
    drive(2'd0, 32'hDEAD_BE41, 4'hF, 0);
    n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_fail++; $display("FAIL basic_first: got valid=%b data=%h want valid=1 data=41", tx_valid, tx_data); end
    drive(2'd0, 32'h0000_0042, 4'hF, 0);
    drive(2'd0, 32'hFFFF_FF43, 4'hF, 0);
    idle(4);
    n_tests++; if (seen.size() != 3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", seen.size()); end
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      n_tests++; if (seen[i] !== want[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h want %h", i, seen[i], want[i]); end
    end
    n_tests++; if (power_off !== 1'b0) begin n_fail++; $display("FAIL basic_power_off: got %b want 0", power_off); end
  endtask

  task automatic test_overflow();
    byte unsigned sent[$];
    logic [31:0] d;
    do_reset();
    tx_ready = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = $urandom;
      sent.push_back(d[7:0]);
      drive(2'd0, d, 4'hF, 0);
    end
    drive(2'd2, 32'h0, 4'h0, 1);
    n_tests++; if (memory_out !== 32'h0000_1006) begin n_fail++; $display("FAIL ovf_status: got %h want 00001006", memory_out); end
    drive(2'd0, $urandom, 4'hF, 0);
    drive(2'd2, 32'h4, 4'hF, 1);
    n_tests++; if (memory_out !== 32'h0000_1006) begin n_fail++; $display("FAIL ovf_prewrite_read: got %h want 00001006", memory_out); end
    drive(2'd2, 32'h0, 4'h0, 1);
    n_tests++; if (memory_out !== 32'h0000_1002) begin n_fail++; $display("FAIL ovf_cleared: got %h want 00001002", memory_out); end
    drive(2'd2, 32'hFFFF_FFFB, 4'hF, 0);
    drive(2'd0, 32'h0, 4'hF, 0);
    drive(2'd2, 32'h0, 4'h0, 1);
    n_tests++; if (memory_out !== 32'h0000_1006) begin n_fail++; $display("FAIL ovf_reset_again: got %h want 00001006", memory_out); end
    tx_ready = 1;
    idle(DEPTH + 4);
    n_tests++; if (seen.size() != DEPTH) begin n_fail++; $display("FAIL ovf_drain_count: got %0d want %0d", seen.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < seen.size(); i++) begin
      n_tests++; if (seen[i] !== sent[i]) begin n_fail++; $display("FAIL ovf_byte%0d: got %h want %h", i, seen[i], sent[i]); end
    end
    drive(2'd2, 32'h0, 4'h0, 1);
    n_tests++; if (memory_out !== 32'h0000_0005) begin n_fail++; $display("FAIL ovf_empty_sticky: got %h want 00000005", memory_out); end
  endtask

  task automatic test_drain();
    byte unsigned sent[$];
    logic [31:0] d;
    do_reset();
    tx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      sent.push_back(d[7:0]);
      drive(2'd0, d, 4'hF, 0);
    end
    drive(2'd1, $urandom, 4'hF, 0);
    drive(2'd2, 32'h0, 4'h0, 1);
    n_tests++; if (memory_out !== 32'h0000_0308) begin n_fail++; $display("FAIL drain_status: got %h want 00000308", memory_out); end
    n_tests++; if (power_off !== 1'b0) begin n_fail++; $display("FAIL drain_power_early: got %b want 0", power_off); end
    drive(2'd0, 32'h77, 4'hF, 0);
    drive(2'd2, 32'h0, 4'h0, 1);
    n_tests++; if (memory_out !== 32'h0000_0308) begin n_fail++; $display("FAIL drain_write_ignored: got %h want 00000308", memory_out); end
    tx_ready = 1;
    idle(3);
    n_tests++; if (tx_valid !== 1'b0 || power_off !== 1'b0) begin n_fail++; $display("FAIL drain_emptied: got valid=%b off=%b want 0 0", tx_valid, power_off); end
    idle(1);
    n_tests++; if (power_off !== 1'b1) begin n_fail++; $display("FAIL drain_power_on_time: got %b want 1", power_off); end
    drive(2'd0, 32'h99, 4'hF, 0);
    idle(5);
    n_tests++; if (power_off !== 1'b1 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL off_sticky: got off=%b valid=%b want 1 0", power_off, tx_valid); end
    n_tests++; if (seen.size() != 3) begin n_fail++; $display("FAIL drain_count: got %0d want 3", seen.size()); end
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      n_tests++; if (seen[i] !== sent[i]) begin n_fail++; $display("FAIL drain_byte%0d: got %h want %h", i, seen[i], sent[i]); end
    end
    drive(2'd2, 32'h0, 4'h0, 1);
    n_tests++; if (memory_out !== 32'h0000_0011) begin n_fail++; $display("FAIL off_status: got %h want 00000011", memory_out); end
  endtask

  task automatic test_partial_we();
    do_reset();
    drive(2'd0, 32'h55, 4'b0011, 0);
    drive(2'd1, 32'h0, 4'b0011, 0);
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL partial_no_push: got %b want 0", tx_valid); end
    drive(2'd2, 32'h0, 4'h0, 1);
    n_tests++; if (memory_out !== 32'h1) begin n_fail++; $display("FAIL partial_status: got %h want 00000001", memory_out); end
    drive(2'd1, 32'h0, 4'hF, 0);
    n_tests++; if (power_off !== 1'b0) begin n_fail++; $display("FAIL empty_power_early: got %b want 0", power_off); end
    drive(2'd2, 32'h0, 4'h0, 1);
    n_tests++; if (memory_out !== 32'h9 || power_off !== 1'b1) begin n_fail++; $display("FAIL empty_power_one_cycle: got status=%h off=%b want 00000009 1", memory_out, power_off); end
  endtask

  task automatic test_reset_drain();
    do_reset();
    tx_ready = 0;
    drive(2'd0, 32'h11, 4'hF, 0);
    drive(2'd0, 32'h22, 4'hF, 0);
    drive(2'd1, 32'h0, 4'hF, 0);
    reset = 1;
    cycle();
    reset = 0;
    n_tests++; if (tx_valid !== 1'b0 || power_off !== 1'b0) begin n_fail++; $display("FAIL rstdrain_outputs: got valid=%b off=%b want 0 0", tx_valid, power_off); end
    drive(2'd2, 32'h0, 4'h0, 1);
    n_tests++; if (memory_out !== 32'h1) begin n_fail++; $display("FAIL rstdrain_status: got %h want 00000001", memory_out); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(99);
      address = (r < 55) ? 2'd0 : (r < 60) ? 2'd1 : (r < 85) ? 2'd2 : 2'd3;
      write_enable = ($urandom_range(9) < 8) ? 4'hF : 4'($urandom);
      read_enable = 1'($urandom);
      memory_in = $urandom;
      tx_ready = ($urandom_range(9) < 4);
      reset = ($urandom_range(199) < 3);
      cycle();
      n_tests++; if (tx_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, tx_valid, q.size() > 0); end
      if (q.size() > 0) begin
        n_tests++; if (tx_data !== q[0]) begin n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", i, tx_data, q[0]); end
      end
      n_tests++; if (power_off !== m_off) begin n_fail++; $display("FAIL rnd_power@%0d: got %b want %b", i, power_off, m_off); end
      n_tests++; if (memory_out !== m_mo) begin n_fail++; $display("FAIL rnd_read@%0d: got %h want %h", i, memory_out, m_mo); end
    end
    reset = 0;
    write_enable = 0;
    read_enable = 0;
    n_tests++; if (seen.size() != exp_out.size()) begin n_fail++; $display("FAIL rnd_stream_len: got %0d want %0d", seen.size(), exp_out.size()); end
    for (int i = 0; i < seen.size() && i < exp_out.size(); i++) begin
      n_tests++; if (seen[i] !== exp_out[i]) begin n_fail++; $display("FAIL rnd_stream%0d: got %h want %h", i, seen[i], exp_out[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_drain();
    test_partial_we();
    test_reset_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
